// File: rtl/trig_angle_cordic_if.sv
// Request/result bundle for the vectoring CORDIC angle unit.
// master drives the request, slave (the unit) returns the angle.
interface trig_angle_cordic_if;
    logic              start;
    logic signed [9:0] sin_val;
    logic signed [9:0] cos_val;
    logic              busy;
    logic              done;
    logic [11:0]       degree;
    logic              invalid;

    modport master (
        output start, sin_val, cos_val,
        input  busy, done, degree, invalid
    );

    modport slave (
        input  start, sin_val, cos_val,
        output busy, done, degree, invalid
    );
endinterface

// File: rtl/trig_angle_cordic.sv
// Iterative vectoring-mode CORDIC: (sin, cos) -> angle in 0.1 deg codes.
// One result every ITERS+3 clocks; done pulses for one cycle.
module trig_angle_cordic #(
    parameter int ITERS = 12,
    parameter int FRAC  = 4,
    parameter int IW    = 14
) (
    input logic             clk,
    input logic             rst,
    trig_angle_cordic_if.slave bus
);
    localparam int ZW = $clog2(3600 << FRAC) + 1;
    localparam int CW = $clog2(ITERS);
    localparam int RW = ZW - FRAC + 1;

    typedef enum logic [1:0] {
        S_IDLE, S_LOAD, S_ITER, S_FINAL
    } state_t;

    state_t               state_q, state_d;
    logic signed [IW-1:0] x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic [CW-1:0]        i_q, i_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;
    logic                 inv_q, inv_d;
    logic [11:0]          deg_q, deg_d;

    logic signed [IW-1:0] xs, ys;
    logic signed [ZW-1:0] a_w, zr;
    logic signed [RW-1:0] r;

    // atan(2^-k) in units of 0.1 deg / 2^12
    function automatic int atan_q12(input int k);
        case (k)
            0:  return 1843200;
            1:  return 1088104;
            2:  return 574925;
            3:  return 291841;
            4:  return 146487;
            5:  return 73315;
            6:  return 36666;
            7:  return 18334;
            8:  return 9167;
            9:  return 4584;
            10: return 2292;
            11: return 1146;
            12: return 573;
            13: return 286;
            default: return 0;
        endcase
    endfunction

    // Rescale the fine table to FRAC fractional bits, rounding half up
    function automatic logic signed [ZW-1:0] atan_c(input logic [CW-1:0] k);
        int t;
        t = atan_q12(int'(k));
        return ZW'((t + (1 << (11 - FRAC))) >>> (12 - FRAC));
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; start outside IDLE is dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_ITER;
            S_ITER:  if (i_q == CW'(ITERS - 1)) state_d = S_FINAL;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: busy follows the non-idle states, results are registered
    always_comb begin
        bus.busy    = (state_q != S_IDLE);
        bus.done    = done_q;
        bus.degree  = deg_q;
        bus.invalid = inv_q;
    end

    // Datapath next-state: latch, pre-rotate, micro-rotate, round/wrap
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        i_d    = i_q;
        zero_d = zero_q;
        done_d = 1'b0;
        inv_d  = inv_q;
        deg_d  = deg_q;
        xs     = x_q >>> i_q;
        ys     = y_q >>> i_q;
        a_w    = atan_c(i_q);
        zr     = z_q + ZW'(1 << (FRAC - 1));
        r      = RW'(zr >>> FRAC);
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d = IW'(bus.cos_val);
                    y_d = IW'(bus.sin_val);
                end
            end
            S_LOAD: begin
                zero_d = (x_q == '0) && (y_q == '0);
                i_d    = '0;
                if (x_q[IW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = ZW'(1800 << FRAC);
                end else begin
                    z_d = '0;
                end
            end
            S_ITER: begin
                i_d = i_q + 1'b1;
                if (!y_q[IW-1]) begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + a_w;
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - a_w;
                end
            end
            S_FINAL: begin
                done_d = 1'b1;
                inv_d  = zero_q;
                // wrap into 0..3599 using modulo-4096 arithmetic on 12 bits
                if (zero_q)
                    deg_d = '0;
                else if (r[RW-1])
                    deg_d = r[11:0] + 12'd3600;
                else if (r >= RW'(3600))
                    deg_d = r[11:0] + 12'd496;
                else
                    deg_d = r[11:0];
            end
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
            inv_q  <= 1'b0;
            deg_q  <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            i_q    <= i_d;
            zero_q <= zero_d;
            done_q <= done_d;
            inv_q  <= inv_d;
            deg_q  <= deg_d;
        end
    end
endmodule
